// File: rtl/tpu_pkg.sv
// Shared array geometry and the packed per-column psum vector type for the
// systolic array datapath.
package tpu_pkg;

  localparam int ARRAY_N   = 4;
  localparam int ACC_WIDTH = 32;

  typedef logic [ARRAY_N-1:0][ACC_WIDTH-1:0] psum_vec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one write and one read per cycle, a registered occupancy
// count, and synchronous active-low reset plus synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_wr && !do_rd)      count_d = count_q + CW'(1);
      else if (do_rd && !do_wr) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i && do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/psum_deskew_fifo.sv
// Aligns the staggered bottom-row psums of the systolic array into whole result
// vectors and queues them for the downstream accumulator on a valid/ready port.
module psum_deskew_fifo
  import tpu_pkg::*;
#(
  parameter int N          = ARRAY_N,
  parameter int ACC_WIDTH  = tpu_pkg::ACC_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [N*ACC_WIDTH-1:0]        psum_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*ACC_WIDTH-1:0]        out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          almost_full,
  output logic                          overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [N*ACC_WIDTH-1:0] aligned;
  logic [N*ACC_WIDTH-1:0] head;
  logic [CW-1:0]          count;
  logic                   push, pop, full, empty;
  logic                   overflow_q, overflow_d;

  // Column j lags column 0 by j cycles, so it needs N-1-j stages to line up.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N-1) begin : g_pass
      assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = psum_in[j*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_dly
      localparam int D = N - 1 - j;
      logic [D*ACC_WIDTH-1:0] dly_q;
      if (D == 1) begin : g_one
        always_ff @(posedge clk) begin
          if (!rst_n) dly_q <= '0;
          else        dly_q <= psum_in[j*ACC_WIDTH +: ACC_WIDTH];
        end
      end else begin : g_many
        always_ff @(posedge clk) begin
          if (!rst_n) dly_q <= '0;
          else        dly_q <= {dly_q[(D-1)*ACC_WIDTH-1:0], psum_in[j*ACC_WIDTH +: ACC_WIDTH]};
        end
      end
      assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = dly_q[D*ACC_WIDTH-1 -: ACC_WIDTH];
    end
  end

  if (N == 1) begin : g_tag_none
    assign push = in_valid & ~clear;
  end else if (N == 2) begin : g_tag_one
    logic tag_q;
    always_ff @(posedge clk) begin
      if (!rst_n || clear) tag_q <= 1'b0;
      else                 tag_q <= in_valid;
    end
    assign push = tag_q;
  end else begin : g_tag_many
    logic [N-2:0] tag_q;
    always_ff @(posedge clk) begin
      if (!rst_n || clear) tag_q <= '0;
      else                 tag_q <= {tag_q[N-3:0], in_valid};
    end
    assign push = tag_q[N-2];
  end

  assign pop = out_valid & out_ready;

  sync_fifo #(
    .WIDTH (N*ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (clear),
    .wr_en_i   (push),
    .wr_data_i (aligned),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (clear)                     overflow_d = 1'b0;
    else if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign out_valid   = ~empty;
  assign out_data    = out_valid ? head : '0;
  assign fifo_count  = count;
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign overflow    = overflow_q;

endmodule
